// File: rtl/mext_issue_pkg.sv
// rtl/mext_issue_pkg.sv - shared RV32M types for the execute-stage multiply/divide issue block
package mext_issue_pkg;

    // Operation classes understood by the multi-cycle mext unit
    typedef enum logic [1:0] {
        m_mul = 2'd0,
        m_div = 2'd1,
        m_rem = 2'd2
    } m_ops;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } issue_state_t;

    // One completed mext operation, kept so an identical follow-up can skip mext
    typedef struct packed {
        logic        valid;
        m_ops        op;
        logic        s1;
        logic        s2;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [63:0] out;
    } m_reuse_t;

    // Architectural rd value from a 64-bit mext result; div/rem always use the low word
    function automatic logic [31:0] m_select(input logic [63:0] out, input logic hi);
        return hi ? out[63:32] : out[31:0];
    endfunction

endpackage

// File: rtl/mext_issue_decode.sv
// rtl/mext_issue_decode.sv - RV32M funct3 to operation, operand signedness and half select
module m_decode
    import mext_issue_pkg::*;
(
    input  logic [2:0] funct3,
    output m_ops       op,
    output logic       s1,
    output logic       s2,
    output logic       hi
);

    // Pure table lookup; also used by ID-stage hazard logic
    always_comb begin
        op = m_mul;
        s1 = 1'b1;
        s2 = 1'b1;
        hi = 1'b0;
        case (funct3)
            F3_MUL:    hi = 1'b0;
            F3_MULH:   hi = 1'b1;
            F3_MULHSU: begin s2 = 1'b0; hi = 1'b1; end
            F3_MULHU:  begin s1 = 1'b0; s2 = 1'b0; hi = 1'b1; end
            F3_DIV:    op = m_div;
            F3_DIVU:   begin op = m_div; s1 = 1'b0; s2 = 1'b0; end
            F3_REM:    op = m_rem;
            default:   begin op = m_rem; s1 = 1'b0; s2 = 1'b0; end
        endcase
    end

endmodule

// File: rtl/mext_issue.sv
// rtl/mext_issue.sv - EX-stage issue, stall and result-reuse control for the mext unit
module mext_issue
    import mext_issue_pkg::*;
#(
    parameter bit REUSE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        advance,
    input  logic        flush,
    output m_ops        mext_mulop,
    output logic [31:0] mext_rs1,
    output logic [31:0] mext_rs2,
    output logic        mext_rs1_signed,
    output logic        mext_rs2_signed,
    output logic        mext_enable,
    input  logic [63:0] mext_out,
    input  logic        mext_pause,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        stall
);

    issue_state_t state;
    m_reuse_t     entry;
    m_ops         op_q;
    logic         s1_q;
    logic         s2_q;
    logic         hi_q;
    logic [31:0]  rs1_q;
    logic [31:0]  rs2_q;
    logic [31:0]  res_q;

    m_ops dec_op;
    logic dec_s1;
    logic dec_s2;
    logic dec_hi;

    m_decode u_decode (
        .funct3 (funct3),
        .op     (dec_op),
        .s1     (dec_s1),
        .s2     (dec_s2),
        .hi     (dec_hi)
    );

    logic operands_match;
    logic exact_match;
    logic mul_low_match;
    logic hit;
    logic issue;

    // MUL's low word is the same for any signedness, so any stored product serves it
    assign operands_match = entry.valid && (rs1 == entry.rs1) && (rs2 == entry.rs2);
    assign exact_match    = (dec_op == entry.op) && (dec_s1 == entry.s1) && (dec_s2 == entry.s2);
    assign mul_low_match  = (funct3 == F3_MUL) && (entry.op == m_mul);
    assign hit   = REUSE_EN && (state == IDLE) && valid && !flush && operands_match
                   && (exact_match || mul_low_match);
    assign issue = (state == IDLE) && valid && !flush && !hit;

    // mext sees only latched values so its inputs stay stable for the whole operation
    assign mext_mulop      = op_q;
    assign mext_rs1        = rs1_q;
    assign mext_rs2        = rs2_q;
    assign mext_rs1_signed = s1_q;
    assign mext_rs2_signed = s2_q;
    assign mext_enable     = (state == BUSY) && !rst;

    assign result_valid = hit || (state == HOLD);
    assign result       = hit ? m_select(entry.out, dec_hi) : ((state == HOLD) ? res_q : 32'd0);
    assign stall        = issue || (state == BUSY);

    // Issue FSM, operand latch, result register and reuse entry
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            entry <= '0;
            op_q  <= m_mul;
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            hi_q  <= 1'b0;
            rs1_q <= 32'd0;
            rs2_q <= 32'd0;
            res_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        op_q  <= dec_op;
                        s1_q  <= dec_s1;
                        s2_q  <= dec_s2;
                        hi_q  <= dec_hi;
                        rs1_q <= rs1;
                        rs2_q <= rs2;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (!mext_pause) begin
                        res_q       <= m_select(mext_out, hi_q);
                        entry.valid <= 1'b1;
                        entry.op    <= op_q;
                        entry.s1    <= s1_q;
                        entry.s2    <= s2_q;
                        entry.rs1   <= rs1_q;
                        entry.rs2   <= rs2_q;
                        entry.out   <= mext_out;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (flush || advance) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mext_issue.sv
// tb/tb_mext_issue.sv - directed bench for mext_issue with a behavioural mext model
module tb_mext_issue;
    import mext_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        advance;
    logic        flush;
    m_ops        mext_mulop;
    logic [31:0] mext_rs1;
    logic [31:0] mext_rs2;
    logic        mext_rs1_signed;
    logic        mext_rs2_signed;
    logic        mext_enable;
    logic [63:0] mext_out;
    logic        mext_pause;
    logic [31:0] result;
    logic        result_valid;
    logic        stall;

    int total = 0;
    int bad   = 0;

    mext_issue dut (
        .clk             (clk),
        .rst             (rst),
        .valid           (valid),
        .funct3          (funct3),
        .rs1             (rs1),
        .rs2             (rs2),
        .advance         (advance),
        .flush           (flush),
        .mext_mulop      (mext_mulop),
        .mext_rs1        (mext_rs1),
        .mext_rs2        (mext_rs2),
        .mext_rs1_signed (mext_rs1_signed),
        .mext_rs2_signed (mext_rs2_signed),
        .mext_enable     (mext_enable),
        .mext_out        (mext_out),
        .mext_pause      (mext_pause),
        .result          (result),
        .result_valid    (result_valid),
        .stall           (stall)
    );

    always #5 clk = ~clk;

    // mext model: enabled-cycle counter, cleared whenever enable is low
    int mcnt = 0;
    always @(posedge clk) begin
        if (!mext_enable) mcnt <= 0;
        else              mcnt <= mcnt + 1;
    end

    // mext model: result and busy time (mul 34, div/rem 33, special cases 2 enabled cycles)
    logic [63:0] a64, b64, prod;
    logic [31:0] q, r;
    logic        ovf;
    int          lat;
    always_comb begin
        a64  = mext_rs1_signed ? {{32{mext_rs1[31]}}, mext_rs1} : {32'd0, mext_rs1};
        b64  = mext_rs2_signed ? {{32{mext_rs2[31]}}, mext_rs2} : {32'd0, mext_rs2};
        prod = a64 * b64;
        ovf  = mext_rs1_signed && (mext_rs1 == 32'h8000_0000) && (mext_rs2 == 32'hFFFF_FFFF);
        q    = 32'd0;
        r    = 32'd0;
        lat  = 33;
        if (mext_rs2 == 32'd0) begin
            q = 32'hFFFF_FFFF; r = mext_rs1; lat = 2;
        end else if (ovf) begin
            q = 32'h8000_0000; r = 32'd0; lat = 2;
        end else if (mext_rs1_signed) begin
            q = $signed(mext_rs1) / $signed(mext_rs2);
            r = $signed(mext_rs1) % $signed(mext_rs2);
        end else begin
            q = mext_rs1 / mext_rs2;
            r = mext_rs1 % mext_rs2;
        end
        mext_out = {32'd0, q};
        if (mext_mulop == m_mul) begin
            mext_out = prod;
            lat = 34;
        end else if (mext_mulop == m_rem) begin
            mext_out = {32'd0, r};
        end
        mext_pause = mext_enable && (mcnt < lat - 1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction, count stall cycles, and check the result once stall drops (ends in HOLD/hit cycle at negedge)
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input int exp_stall, input logic [31:0] exp_res);
        int n;
        n = 0;
        valid = 1'b1; funct3 = f3; rs1 = a; rs2 = b; advance = 1'b0; flush = 1'b0;
        @(negedge clk);
        while (stall && n < 200) begin
            if (n == 0) chk({tag, "_en_issue"}, {31'd0, mext_enable}, 32'd0);
            if (n == 2) chk({tag, "_en_busy"}, {31'd0, mext_enable}, 32'd1);
            if (n == 2) chk({tag, "_mext_rs1"}, mext_rs1, a);
            n++;
            @(negedge clk);
        end
        chk({tag, "_stall_cycles"}, n, exp_stall);
        chk({tag, "_valid"}, {31'd0, result_valid}, 32'd1);
        chk({tag, "_result"}, result, exp_res);
    endtask

    task automatic retire(input string tag);
        advance = 1'b1;
        step();
        advance = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_valid"}, {31'd0, result_valid}, 32'd0);
        chk({tag, "_idle_stall"}, {31'd0, stall}, 32'd0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; valid = 1'b0; funct3 = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
        advance = 1'b0; flush = 1'b0;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_enable", {31'd0, mext_enable}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_mext_rs1", mext_rs1, 32'd0);
        step();

        // MUL 7 * -3, then hold without advance
        run_op("mul", F3_MUL, 32'd7, 32'hFFFF_FFFD, 35, 32'hFFFF_FFEB);
        step();
        @(negedge clk);
        chk("mul_hold_valid", {31'd0, result_valid}, 32'd1);
        chk("mul_hold_result", result, 32'hFFFF_FFEB);
        retire("mul");

        // MULH then MUL on identical operands: second is a reuse hit
        run_op("mulh", F3_MULH, 32'h8000_0000, 32'h8000_0000, 35, 32'h4000_0000);
        retire("mulh");
        run_op("mul_hit", F3_MUL, 32'h8000_0000, 32'h8000_0000, 0, 32'h0000_0000);
        retire("mul_hit");

        // DIVU then REMU: different op, so no reuse
        run_op("divu", F3_DIVU, 32'd100, 32'd7, 34, 32'd14);
        retire("divu");
        run_op("remu", F3_REMU, 32'd100, 32'd7, 34, 32'd2);
        retire("remu");

        // mext special cases; REM must not reuse the DIV entry
        run_op("div0", F3_DIV, 32'd5, 32'd0, 3, 32'hFFFF_FFFF);
        retire("div0");
        run_op("rem0", F3_REM, 32'd5, 32'd0, 3, 32'd5);
        retire("rem0");
        run_op("divovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 3, 32'h8000_0000);
        retire("divovf");

        // Flush at BUSY cycle 10
        valid = 1'b1; funct3 = F3_MULHU; rs1 = 32'hFFFF_FFFF; rs2 = 32'd2;
        repeat (10) step();
        flush = 1'b1;
        valid = 1'b0;
        @(negedge clk);
        chk("flush_en_same_cycle", {31'd0, mext_enable}, 32'd1);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_en_next", {31'd0, mext_enable}, 32'd0);
        chk("flush_stall", {31'd0, stall}, 32'd0);
        chk("flush_valid", {31'd0, result_valid}, 32'd0);
        step();
        run_op("mulhu", F3_MULHU, 32'hFFFF_FFFF, 32'd2, 35, 32'd1);
        retire("mulhu");

        // Flush coinciding with completion: entry must stay unwritten
        valid = 1'b1; funct3 = F3_MUL; rs1 = 32'd3; rs2 = 32'd5;
        n = 0;
        @(negedge clk);
        while (!(mext_enable && !mext_pause) && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("fc_done_cycle", n, 34);
        flush = 1'b1;
        valid = 1'b0;
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("fc_valid", {31'd0, result_valid}, 32'd0);
        step();
        run_op("fc_reissue", F3_MUL, 32'd3, 32'd5, 35, 32'd15);
        retire("fc_reissue");
        run_op("mulh_hit", F3_MULH, 32'd3, 32'd5, 0, 32'd0);
        retire("mulh_hit");

        // Reset during BUSY invalidates the entry
        valid = 1'b1; funct3 = F3_DIVU; rs1 = 32'd9; rs2 = 32'd2;
        repeat (5) step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy_en", {31'd0, mext_enable}, 32'd0);
        step();
        rst = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        chk("rst_busy_stall", {31'd0, stall}, 32'd0);
        step();
        run_op("post_rst", F3_MUL, 32'd3, 32'd5, 35, 32'd15);
        retire("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mext_issue.md
Name: mext_issue

Overview:
- Execute-stage control block that sits directly upstream of the multi-cycle M-extension multiply/divide unit (mext) and consumes its result.
- Decodes RV32M funct3 into an m_ops operation and operand signedness, then latches the operands and holds mext enable until completion.
- Captures the 64-bit product or quotient/remainder, selects the architectural 32-bit result, and stalls the pipeline for the duration.
- Keeps a one-entry result-reuse register so that back-to-back M instructions with identical operands (e.g. MULH followed by MUL) complete with zero added latency.

Parameters:
REUSE_EN, 1, enables the one-entry result-reuse register (0 = every instruction issues to mext)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
valid  input  1  an M-extension instruction occupies EX this cycle
funct3  input  3  RV32M funct3 of that instruction
rs1  input  32  forwarded rs1 value
rs2  input  32  forwarded rs2 value
advance  input  1  pipeline moves EX forward at this clock edge
flush  input  1  kill the instruction in EX (branch mispredict)
mext_mulop  output  m_ops  operation to mext (from latched state)
mext_rs1  output  32  latched rs1 to mext
mext_rs2  output  32  latched rs2 to mext
mext_rs1_signed  output  1  rs1 signedness to mext
mext_rs2_signed  output  1  rs2 signedness to mext
mext_enable  output  1  mext enable
mext_out  input  64  mext result, valid when mext_pause=0 with enable=1
mext_pause  input  1  mext busy
result  output  32  architectural rd value
result_valid  output  1  result is valid this cycle
stall  output  1  freeze IF/ID/EX

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- funct3 decode:
  - 000 MUL: m_mul, s/s, low half.
  - 001 MULH: m_mul, s/s, high half.
  - 010 MULHSU: m_mul, s/u, high half.
  - 011 MULHU: m_mul, u/u, high half.
  - 100 DIV: m_div, s.
  - 101 DIVU: m_div, u.
  - 110 REM: m_rem, s.
  - 111 REMU: m_rem, u.
  - For div/rem, result = out[31:0].
- States: IDLE, BUSY, HOLD. Reset → IDLE, reuse entry invalid, all outputs 0.
- IDLE:
  - valid & !flush & reuse hit → result = selected half of the stored 64-bit entry, result_valid=1, stall=0; state stays IDLE.
  - valid & !flush & miss → latch funct3/rs1/rs2, stall=1, go BUSY. mext_enable=0 in this cycle.
- BUSY:
  - mext_enable=1, stall=1, mext_* driven only from latched registers (stable for the whole operation).
  - When mext_pause=0: write mext_out into the result register and the reuse entry, then go HOLD.
- HOLD:
  - mext_enable=0 (required so mext returns to idle), result_valid=1, stall=0.
  - advance → IDLE; otherwise remain in HOLD holding result.
- Reuse hit condition:
  - Entry valid, rs1/rs2 match the entry, and one of:
    - mulop and both signedness bits match the entry; or
    - the instruction is MUL and the entry is any m_mul (low 32 bits are signedness-independent).
  - DIV and REM never share an entry.
  - REUSE_EN=0 forces miss.
- flush:
  - In BUSY → IDLE next cycle, mext_enable drops, no entry write.
  - In HOLD → IDLE.
  - Flush wins over a simultaneous completion: the entry is not written.
- The reuse entry is invalidated on rst only. Operand values are compared directly, so no register-write snoop is needed.
- rst mid-operation: IDLE next edge, enable=0, entry invalid.
- Latency on a miss, given mext timing:
  - MUL-class: stall high 35 cycles (1 IDLE + 34 BUSY).
  - DIV/REM: 34 cycles.
  - mext special cases (divide by zero, 0x80000000 / -1): 3 cycles.

Decomposition:
- Add to rv32i_types:
  - funct3 localparams for the eight RV32M ops.
  - enum issue_state_t {IDLE, BUSY, HOLD}.
  - Packed struct m_reuse_t {valid, m_ops op, s1, s2, rs1[31:0], rs2[31:0], out[63:0]}.
- One natural sub-module: m_decode (combinational funct3 → op, signedness, half select), shared with ID-stage hazard logic.

Test Plan:
- MUL 7×(−3) miss → stall 35 cycles, then result=0xFFFFFFEB, result_valid=1 in HOLD; advance → IDLE.
- MULH 0x80000000×0x80000000 then MUL with the same operands next → first result 0x40000000 after stall; second result 0x00000000 with stall=0 (reuse hit).
- DIVU 100/7 then REMU 100/7 → 14 after 34 stall cycles, then a miss issue → 2.
- DIV 5/0 → 0xFFFFFFFF after 3 stall cycles; DIV 0x80000000/0xFFFFFFFF → 0x80000000.
- flush at BUSY cycle 10, then MULHU 0xFFFFFFFF×2 → enable drops next cycle, no entry write; new op gives result=1.
- rst during BUSY, then the same operands reissued → a miss (full latency), mext_enable=0 in the reset cycle.
